// File: rtl/imem_loader_if.sv
// imem_loader_if: valid/ready instruction stream feeding the loader
interface imem_loader_if #(parameter int WORD_W = 6);
    logic                valid;
    logic [3*WORD_W-1:0] data;
    logic                last;
    logic                ready;
    modport master(output valid, data, last, input ready);
    modport slave(input valid, data, last, output ready);
endinterface

// File: rtl/imem_loader.sv
// imem_loader: splits each instruction into three MSB-first word writes; IMEM_LOADER_CHECKSUM_EN adds an XOR checksum port
module imem_loader #(
    parameter int DEPTH  = 128,
    parameter int ADDR_W = 7,
    parameter int WORD_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    imem_loader_if.slave      s_in,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [WORD_W-1:0] o_mem_wdata,
    output logic              o_run,
    output logic              o_err,
    output logic [ADDR_W-1:0] o_instr_count
`ifdef IMEM_LOADER_CHECKSUM_EN
    ,
    output logic [WORD_W-1:0] o_checksum
`endif
);
    typedef enum logic [2:0] {IDLE, ACCEPT, WR0, WR1, WR2, DONE, ERR} state_t;
    localparam logic [ADDR_W:0] PTR_MAX = (ADDR_W+1)'(DEPTH - 3);
    state_t              r_state, w_next;
    logic [ADDR_W:0]     r_ptr;
    logic [ADDR_W-1:0]   r_count, r_addr, w_addr;
    logic [WORD_W-1:0]   r_wdata, w_word;
    logic [3*WORD_W-1:0] r_instr;
    logic                r_last, w_ready, w_hs, w_restart, w_wr_next;
    logic [1:0]          w_off;
    always_comb begin
        w_ready   = r_state == ACCEPT && r_ptr <= PTR_MAX;
        w_hs      = w_ready && s_in.valid;
        w_restart = i_start && (r_state == IDLE || r_state == DONE || r_state == ERR);
        w_next    = r_state;
        case (r_state)
            IDLE, DONE, ERR: w_next = i_start ? ACCEPT : r_state;
            ACCEPT:          w_next = !w_ready ? ERR : s_in.valid ? WR0 : ACCEPT;
            WR0:             w_next = WR1;
            WR1:             w_next = WR2;
            WR2:             w_next = r_last ? DONE : ACCEPT;
            default:         w_next = IDLE;
        endcase
        // Address/data are registered one cycle ahead so they line up with the Moore write enable
        w_wr_next = w_next inside {WR0, WR1, WR2};
        w_off     = r_state == WR0 ? 2'd1 : r_state == WR1 ? 2'd2 : 2'd0;
        w_addr    = ADDR_W'(r_ptr + (ADDR_W+1)'(w_off));
        w_word    = r_state == ACCEPT ? s_in.data[3*WORD_W-1 -: WORD_W]
                  : r_state == WR0    ? r_instr[2*WORD_W-1 -: WORD_W]
                  :                     r_instr[WORD_W-1:0];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_count <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_instr <= '0;
            r_last  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_restart) begin
                r_ptr   <= '0;
                r_count <= '0;
            end
            if (w_hs) begin
                r_instr <= s_in.data;
                r_last  <= s_in.last;
            end
            if (r_state == WR2) begin
                r_ptr   <= r_ptr + (ADDR_W+1)'(3);
                r_count <= r_count + 1'b1;
            end
            if (w_wr_next) begin
                r_addr  <= w_addr;
                r_wdata <= w_word;
            end
        end
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [WORD_W-1:0] r_csum;
    always_ff @(posedge clk)
        r_csum <= (rst || w_restart) ? '0 : w_wr_next ? r_csum ^ w_word : r_csum;
    assign o_checksum = r_csum;
`endif
    always_comb begin
        s_in.ready    = w_ready;
        o_mem_we      = r_state inside {WR0, WR1, WR2};
        o_mem_addr    = r_addr;
        o_mem_wdata   = r_wdata;
        o_run         = r_state == DONE;
        o_err         = r_state == ERR;
        o_instr_count = r_count;
    end
endmodule
